morse_word_assembler: RTL and testbench
=======================================

Name: morse_word_assembler

Overview:
- Parametrised next-generation word builder for the Morse receive path. It takes recognised character codes one per strobe and assembles them into a live word register.
- On each word boundary it commits the finished word, with its length, error and truncation flags, into a small FIFO.
- Downstream consumers (display, UART formatter) drain the FIFO through a valid/ready handshake.
- Adds configurable width and depth, an overflow policy, length tracking, word buffering and drop accounting.

Parameters:
- CHAR_W, `CHAR_W: bits per character code.
- MAX_CHARS, `MAX_CHARS: character slots per word; must be ≥1.
- SPACE_CODE, `CHAR_CODE_SPACE: fill code for unused slots.
- DEPTH, 4: committed-word FIFO entries; must be a power of two, ≥2.
- OVF_MODE, 0: policy when a word exceeds MAX_CHARS. 0 = shift out the oldest character. 1 = keep the first MAX_CHARS characters and drop new ones.
- CNT_W, $clog2(MAX_CHARS+1): length field width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable. All state updates are qualified by ce, except reset and the output pop.
- char_valid  in  1  strobe: char_in is a new recognised character.
- char_in  in  CHAR_W  recognised character code.
- error_in  in  1  recogniser error for char_in.
- word_end  in  1  word-gap detected.
- live_word  out  CHAR_W*MAX_CHARS  word under construction. Newest character is in slot 0 (LSBs).
- live_len  out  CNT_W  characters held in live_word, 0..MAX_CHARS.
- live_active  out  1  a word is being built.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head entry.
- out_word  out  CHAR_W*MAX_CHARS  head entry word.
- out_len  out  CNT_W  head entry length.
- out_error  out  1  head entry error flag.
- out_trunc  out  1  head entry truncation flag.
- drop_count  out  8  number of words lost because the FIFO was full; saturates at 255.

Behaviour:
- Reset (async, rst_n=0):
  - live_word all SPACE_CODE; live_len 0; live_active 0.
  - FIFO emptied: out_valid 0, pointers 0. out_word/out_len/out_error/out_trunc are don't-care while out_valid=0.
  - drop_count 0.
  - Reset during a word discards that word; it is not committed.
- Builder FSM, states IDLE (live_active=0) and BUILD (live_active=1). Advances only when ce=1.
- IDLE & char_valid & !word_end:
  - live_word becomes {SPACE_CODE…, char_in}; live_len=1.
  - word error = error_in; trunc = 0.
  - Go to BUILD.
- BUILD & char_valid & !word_end, live_len<MAX_CHARS:
  - live_word shifts up one slot; char_in enters slot 0; live_len+1.
  - error |= error_in.
- BUILD & char_valid & !word_end, live_len==MAX_CHARS:
  - OVF_MODE 0: shift as above, oldest character lost; live_len stays MAX_CHARS; trunc=1; error |= error_in.
  - OVF_MODE 1: live_word unchanged; trunc=1; error unchanged (the dropped character's error is discarded).
- word_end=1 (ce=1):
  - Takes priority. Any char_valid in the same cycle is ignored.
  - In BUILD: commit {live_word, live_len, error, trunc} to the FIFO, then go to IDLE. live_word and live_len hold their values until the next word starts.
  - In IDLE: no effect; empty words are never committed.
- error_in is sampled only together with an accepted char_valid.
- FIFO:
  - Show-ahead: out_* reflect mem[rd_ptr] combinationally; out_valid = !empty.
  - Pop when out_valid & out_ready, independent of ce.
  - Commit latency: word_end sampled at edge N → out_valid=1 after edge N when the FIFO was previously empty.
  - Push is accepted if not full, or if a pop occurs in the same cycle (full + pop + push keeps the FIFO full and admits the new word).
  - Push while full and no pop: word dropped, FIFO unchanged, drop_count+1 saturating at 255.
  - Pointers are ($clog2(DEPTH)+1) bits and wrap naturally.
  - Simultaneous push and pop on an empty FIFO cannot occur because out_valid=0.
- ce=0 freezes the builder and blocks push. Pop still operates.

Test Plan:
- Reset, then with ce=1, MAX_CHARS=8, chars 5,7,9 then word_end → one FIFO entry: slots0..2 = 9,7,5, remaining slots SPACE_CODE; out_len=3; out_error=0; out_trunc=0; out_valid high the cycle after word_end.
- 10 chars 1..10 then word_end, OVF_MODE 0 → slots0..7 = 10..3, len 8, trunc 1. Same stimulus with OVF_MODE 1 → slots0..7 = 8..1, trunc 1.
- Hold out_ready=0 and commit 6 one-character words, DEPTH=4 → 4 entries held; drop_count=2. Drain → entries come out in commit order, then out_valid=0.
- FIFO full, then out_ready=1 in the same cycle as word_end → new word accepted; drop_count unchanged; occupancy stays 4.
- error_in=1 on the 2nd of 3 chars → out_error=1. Next word with clean chars → out_error=0. char_valid asserted in the same cycle as word_end → that char is absent from the committed word.
- Assert rst_n low mid-word (live_len=2) → live_len=0, out_valid=0, nothing committed. A subsequent word_end in IDLE → no FIFO entry.

Source files
------------

// File: rtl/morse_word_assembler.sv
// morse_word_assembler: builds words from character strobes and queues finished words in a show-ahead FIFO
module morse_word_assembler #(
  parameter int CHAR_W = 6,
  parameter int MAX_CHARS = 8,
  parameter logic [CHAR_W-1:0] SPACE_CODE = '1,
  parameter int DEPTH = 4,
  parameter int OVF_MODE = 0,
  parameter int CNT_W = $clog2(MAX_CHARS+1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic                        char_valid,
  input  logic [CHAR_W-1:0]           char_in,
  input  logic                        error_in,
  input  logic                        word_end,
  output logic [CHAR_W*MAX_CHARS-1:0] live_word,
  output logic [CNT_W-1:0]            live_len,
  output logic                        live_active,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHAR_W*MAX_CHARS-1:0] out_word,
  output logic [CNT_W-1:0]            out_len,
  output logic                        out_error,
  output logic                        out_trunc,
  output logic [7:0]                  drop_count
);
  localparam int WW = CHAR_W*MAX_CHARS;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = WW+CNT_W+2;
  typedef enum logic {IDLE, BUILD} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] word_q, word_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic err_q, err_d, trunc_q, trunc_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0] drop_q, drop_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;
  logic [WW-1:0] shifted, started;
  logic push, pop, full, empty, push_ok;
  assign shifted = (word_q << CHAR_W) | WW'(char_in);
  assign started = ({MAX_CHARS{SPACE_CODE}} << CHAR_W) | WW'(char_in);
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    len_d = len_q;
    err_d = err_q;
    trunc_d = trunc_q;
    push = 1'b0;
    if (ce) begin
      if (word_end) begin
        push = state_q == BUILD;
        state_d = IDLE;
      end else if (char_valid) begin
        if (state_q == IDLE) begin
          word_d = started;
          len_d = CNT_W'(1);
          err_d = error_in;
          trunc_d = 1'b0;
          state_d = BUILD;
        end else if (len_q < CNT_W'(MAX_CHARS)) begin
          word_d = shifted;
          len_d = len_q + CNT_W'(1);
          err_d = err_q | error_in;
        end else begin
          // full word: mode 0 slides the window, mode 1 freezes the first characters
          trunc_d = 1'b1;
          word_d = OVF_MODE == 0 ? shifted : word_q;
          err_d = OVF_MODE == 0 ? err_q | error_in : err_q;
        end
      end
    end
  end
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop = !empty && out_ready;
  assign push_ok = push && (!full || pop);
  always_comb begin
    wr_d = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    drop_d = (push && full && !pop && drop_q != 8'd255) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      word_q <= {MAX_CHARS{SPACE_CODE}};
      len_q <= '0;
      err_q <= 1'b0;
      trunc_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      len_q <= len_d;
      err_q <= err_d;
      trunc_q <= trunc_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      drop_q <= drop_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_q[AW-1:0]] <= {word_q, len_q, err_q, trunc_q};
  assign head = mem_q[rd_q[AW-1:0]];
  assign live_word = word_q;
  assign live_len = len_q;
  assign live_active = state_q == BUILD;
  assign out_valid = !empty;
  assign out_word = head[EW-1:CNT_W+2];
  assign out_len = head[CNT_W+1:2];
  assign out_error = head[1];
  assign out_trunc = head[0];
  assign drop_count = drop_q;
endmodule

// File: tb/tb_morse_word_assembler.sv
// tb_morse_word_assembler: directed vectors plus hand sequences for both overflow policies
module tb_morse_word_assembler;
  localparam logic [5:0] SP = 6'd63;
  logic clk = 0, rst_n = 0, ce = 1, char_valid = 0, error_in = 0, word_end = 0, out_ready = 0;
  logic [5:0] char_in = 0;
  logic [47:0] lw0, lw1, ow0, ow1;
  logic [3:0] ll0, ll1, ol0, ol1;
  logic la0, la1, ov0, ov1, oe0, oe1, ot0, ot1;
  logic [7:0] dc0, dc1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  morse_word_assembler #(.CHAR_W(6), .MAX_CHARS(8), .SPACE_CODE(SP), .DEPTH(4), .OVF_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .char_valid(char_valid), .char_in(char_in), .error_in(error_in),
    .word_end(word_end), .live_word(lw0), .live_len(ll0), .live_active(la0), .out_valid(ov0),
    .out_ready(out_ready), .out_word(ow0), .out_len(ol0), .out_error(oe0), .out_trunc(ot0), .drop_count(dc0));
  morse_word_assembler #(.CHAR_W(6), .MAX_CHARS(8), .SPACE_CODE(SP), .DEPTH(4), .OVF_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .char_valid(char_valid), .char_in(char_in), .error_in(error_in),
    .word_end(word_end), .live_word(lw1), .live_len(ll1), .live_active(la1), .out_valid(ov1),
    .out_ready(out_ready), .out_word(ow1), .out_len(ol1), .out_error(oe1), .out_trunc(ot1), .drop_count(dc1));

  typedef struct {
    logic ce, cv;
    logic [5:0] ch;
    logic er, we, rdy;
    logic [3:0] len;
    logic act, vld;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic cv, input logic [5:0] ch, input logic er, input logic we, input logic rdy);
    @(negedge clk);
    ce = c; char_valid = cv; char_in = ch; error_in = er; word_end = we; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] wexp(input int n, input int newest, input int step);
    logic [47:0] w;
    for (int i = 0; i < 8; i++) w[i*6+:6] = i < n ? 6'(newest - i*step) : SP;
    return w;
  endfunction

  initial begin
    tbl[0] = '{1, 1, 6'd5, 0, 0, 0, 4'd1, 1, 0};
    tbl[1] = '{1, 1, 6'd7, 0, 0, 0, 4'd2, 1, 0};
    tbl[2] = '{1, 1, 6'd9, 0, 0, 0, 4'd3, 1, 0};
    tbl[3] = '{1, 0, 6'd0, 0, 1, 0, 4'd3, 0, 1};
    tbl[4] = '{0, 1, 6'd4, 0, 0, 0, 4'd3, 0, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_live_len", ll0, 0);
    chk("rst_live_word", lw0, {8{SP}});
    chk("rst_active", la0, 0);
    chk("rst_valid", ov0, 0);
    chk("rst_drop", dc0, 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(tbl[i].ce, tbl[i].cv, tbl[i].ch, tbl[i].er, tbl[i].we, tbl[i].rdy);
      chk($sformatf("vec%0d_len", i), ll0, tbl[i].len);
      chk($sformatf("vec%0d_active", i), la0, tbl[i].act);
      chk($sformatf("vec%0d_valid", i), ov0, tbl[i].vld);
    end
    chk("w1_word", ow0, wexp(3, 9, 2));
    chk("w1_len", ol0, 3);
    chk("w1_err", oe0, 0);
    chk("w1_trunc", ot0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    chk("w1_drained", ov0, 0);
    for (int k = 1; k <= 10; k++) cyc(1, 1, 6'(k), 0, 0, 0);
    chk("ovf0_live_len", ll0, 8);
    chk("ovf1_live_len", ll1, 8);
    cyc(1, 0, 0, 0, 1, 0);
    chk("ovf0_word", ow0, wexp(8, 10, 1));
    chk("ovf0_trunc", ot0, 1);
    chk("ovf0_len", ol0, 8);
    chk("ovf1_word", ow1, wexp(8, 8, 1));
    chk("ovf1_trunc", ot1, 1);
    chk("ovf1_len", ol1, 8);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 6'd3, 0, 0, 0);
    cyc(1, 1, 6'd4, 1, 0, 0);
    cyc(1, 1, 6'd5, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("err_flag", oe0, 1);
    chk("err_word", ow0, wexp(3, 5, 1));
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 6'd6, 0, 0, 0);
    cyc(1, 1, 6'd7, 0, 0, 0);
    cyc(1, 1, 6'd8, 1, 1, 0);
    chk("clean_err", oe0, 0);
    chk("we_char_word", ow0, wexp(2, 7, 1));
    chk("we_char_len", ol0, 2);
    chk("we_char_live_len", ll0, 2);
    cyc(1, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 1, 6'(k), 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 0);
    end
    chk("full_drop", dc0, 2);
    chk("full_head", ow0, wexp(1, 1, 1));
    cyc(1, 1, 6'd7, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1);
    chk("pop_push_drop", dc0, 2);
    begin
      int eh[4] = '{2, 3, 4, 7};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("drain%0d_valid", i), ov0, 1);
        chk($sformatf("drain%0d_word", i), ow0, wexp(1, eh[i], 1));
        chk($sformatf("drain%0d_len", i), ol0, 1);
        cyc(1, 0, 0, 0, 0, 1);
      end
    end
    chk("drain_empty", ov0, 0);
    cyc(1, 1, 6'd1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 1, 6'd2, 0, 0, 0);
    cyc(1, 1, 6'd3, 0, 0, 0);
    chk("mid_len", ll0, 2);
    chk("mid_valid", ov0, 1);
    @(negedge clk);
    char_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_len", ll0, 0);
    chk("mid_rst_valid", ov0, 0);
    chk("mid_rst_active", la0, 0);
    @(negedge clk) rst_n = 1;
    cyc(1, 0, 0, 0, 1, 0);
    chk("idle_we_valid", ov0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("idle_we_valid2", ov0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
